// File: rtl/alu_issue_ctrl.sv
// MIPS ALU issue/capture controller; optional LOCAL_SLT_NOR_EN computes SLT/NOR results locally.
// Latency: accept -> out_valid after 2+ALU_LAT edges; result held until out_ready, in_ready only in IDLE.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } dec_t;

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_t           state_q, state_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_illegal_q, out_illegal_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [3:0]       wait_q, wait_d;
  dec_t             dec;
  logic [31:0]      cap_val;
  logic [5:0]       opcode, funct;
  logic [15:0]      imm;
  logic             unused_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  // rs field and shamt are not needed: rs arrives already read as rs_data.
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec.op      = 4'b0000;
    dec.b       = rt_data;
    dec.rd      = instr[20:16];
    dec.illegal = 1'b0;
    if (opcode == 6'h00) begin
      dec.rd = instr[15:11];
      case (funct)
        6'h24:        dec.op = 4'b0000;
        6'h25:        dec.op = 4'b0001;
        6'h20, 6'h21: dec.op = 4'b0010;
        6'h22, 6'h23: dec.op = 4'b0110;
        6'h2A:        dec.op = 4'b0111;
        6'h27:        dec.op = 4'b1100;
        default:      dec.illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09: begin dec.op = 4'b0010; dec.b = {{16{imm[15]}}, imm}; end
        6'h0A:        begin dec.op = 4'b0111; dec.b = {{16{imm[15]}}, imm}; end
        6'h0C:        begin dec.op = 4'b0000; dec.b = {16'h0000, imm}; end
        6'h0D:        begin dec.op = 4'b0001; dec.b = {16'h0000, imm}; end
        default:      dec.illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    cap_val = alu_result;
`ifdef LOCAL_SLT_NOR_EN
    case (alu_op_q)
      4'b0111: cap_val = {31'b0, ($signed(alu_a_q) < $signed(alu_b_q))};
      4'b1100: cap_val = ~(alu_a_q | alu_b_q);
      default: cap_val = alu_result;
    endcase
`endif
  end

  always_comb begin
    state_d       = state_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    op_count_d    = op_count_q;
    wait_d        = wait_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_rd_d = dec.rd;
          if (dec.illegal) begin
            // Illegal ops skip the ALU entirely and leave its inputs untouched.
            out_illegal_d = 1'b1;
            out_result_d  = 32'h0;
            state_d       = HOLD;
          end else begin
            out_illegal_d = 1'b0;
            alu_op_d      = dec.op;
            alu_a_d       = rs_data;
            alu_b_d       = dec.b;
            wait_d        = 4'd0;
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == LAT) state_d = CAPTURE;
      end
      CAPTURE: begin
        out_result_d = cap_val;
        state_d      = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      alu_op_q      <= 4'b0000;
      alu_a_q       <= 32'h0;
      alu_b_q       <= 32'h0;
      out_result_q  <= 32'h0;
      out_rd_q      <= 5'd0;
      out_illegal_q <= 1'b0;
      op_count_q    <= '0;
      wait_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
      op_count_q    <= op_count_d;
      wait_q        <= wait_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with ALU_LAT=0, one with ALU_LAT=3 and a 2-bit counter.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, out_ready, alu_force;
  logic [31:0] instr, rs_data, rt_data;

  logic        in_valid0, in_ready0, out_valid0, out_illegal0;
  logic [3:0]  alu_op0;
  logic [31:0] alu_a0, alu_b0, alu_result0, out_result0;
  logic [4:0]  out_rd0;
  logic [15:0] op_count0;

  logic        in_valid3, in_ready3, out_valid3, out_illegal3;
  logic [3:0]  alu_op3;
  logic [31:0] alu_a3, alu_b3, alu_result3, out_result3;
  logic [4:0]  out_rd3;
  logic [1:0]  op_count3;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef LOCAL_SLT_NOR_EN
  localparam logic [31:0] SLT_EXP = 32'd1;
  localparam logic [31:0] NOR_EXP = 32'hF0F0_FF0F;
`else
  localparam logic [31:0] SLT_EXP = 32'hDEAD_BEEF;
  localparam logic [31:0] NOR_EXP = 32'hDEAD_BEEF;
`endif

  alu_issue_ctrl #(.ALU_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_op(alu_op0), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_result(alu_result0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(out_result0), .out_rd(out_rd0), .out_illegal(out_illegal0), .op_count(op_count0));

  alu_issue_ctrl #(.ALU_LAT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .out_valid(out_valid3), .out_ready(out_ready),
    .out_result(out_result3), .out_rd(out_rd3), .out_illegal(out_illegal3), .op_count(op_count3));

  // Reference ALU; alu_force makes it return a marker so capture sourcing is visible.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, ($signed(a) < $signed(b))};
      4'b1100: return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result0 = alu_force ? 32'hDEAD_BEEF : alu_f(alu_op0, alu_a0, alu_b0);
  assign alu_result3 = alu_force ? 32'hDEAD_BEEF : alu_f(alu_op3, alu_a3, alu_b3);

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept0(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i; rs_data = a; rt_data = b; in_valid0 = 1'b1;
    cyc();
    in_valid0 = 1'b0;
  endtask

  task automatic accept3(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i; rs_data = a; rt_data = b; in_valid3 = 1'b1;
    cyc();
    in_valid3 = 1'b0;
  endtask

  // Returns number of edges after the accept edge until out_valid is seen.
  task automatic wait_valid0(output int k);
    k = 0;
    while (!out_valid0 && k < 30) begin cyc(); k++; end
  endtask

  task automatic wait_valid3(output int k);
    k = 0;
    while (!out_valid3 && k < 30) begin cyc(); k++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; alu_force = 1'b0;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0; in_valid0 = 1'b0; in_valid3 = 1'b0;
    repeat (3) cyc();
    n_cmp++; if ({in_ready0, out_valid0, out_illegal0} !== 3'b100) begin n_bad++; $display("FAIL reset_flags got %b want 100", {in_ready0, out_valid0, out_illegal0}); end
    n_cmp++; if ({alu_op0, alu_a0, alu_b0} !== 68'h0) begin n_bad++; $display("FAIL reset_alu got %h want 0", {alu_op0, alu_a0, alu_b0}); end
    n_cmp++; if ({out_result0, out_rd0, op_count0} !== 53'h0) begin n_bad++; $display("FAIL reset_out got %h want 0", {out_result0, out_rd0, op_count0}); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    accept0(rtype(5'd1, 5'd1, 5'd3, 6'h20), 32'd1, 32'd1);
    n_cmp++; if (in_ready0 !== 1'b0) begin n_bad++; $display("FAIL add_busy got %b want 0", in_ready0); end
    n_cmp++; if ({alu_op0, alu_a0, alu_b0} !== {4'b0010, 32'd1, 32'd1}) begin n_bad++; $display("FAIL add_issue got %h want %h", {alu_op0, alu_a0, alu_b0}, {4'b0010, 32'd1, 32'd1}); end
    n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL add_early1 got %b want 0", out_valid0); end
    cyc();
    n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL add_early2 got %b want 0", out_valid0); end
    cyc();
    n_cmp++; if ({out_valid0, out_illegal0, out_result0, out_rd0} !== {1'b1, 1'b0, 32'd2, 5'd3}) begin n_bad++; $display("FAIL add_result got %h want %h", {out_valid0, out_illegal0, out_result0, out_rd0}, {1'b1, 1'b0, 32'd2, 5'd3}); end
    n_cmp++; if (op_count0 !== 16'd0) begin n_bad++; $display("FAIL add_cnt_pre got %0d want 0", op_count0); end
    cyc();
    n_cmp++; if ({out_valid0, in_ready0, op_count0} !== {1'b0, 1'b1, 16'd1}) begin n_bad++; $display("FAIL add_done got %h want %h", {out_valid0, in_ready0, op_count0}, {1'b0, 1'b1, 16'd1}); end
  endtask

  task automatic test_imm();
    int k;
    accept0(itype(6'h08, 5'd2, 5'd7, 16'hFFFF), 32'd5, 32'd0);
    n_cmp++; if ({alu_op0, alu_b0} !== {4'b0010, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL addi_issue got %h want %h", {alu_op0, alu_b0}, {4'b0010, 32'hFFFF_FFFF}); end
    wait_valid0(k);
    n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL addi_latency got %0d want 2", k); end
    n_cmp++; if ({out_result0, out_rd0} !== {32'd4, 5'd7}) begin n_bad++; $display("FAIL addi_result got %h want %h", {out_result0, out_rd0}, {32'd4, 5'd7}); end
    cyc();
    accept0(itype(6'h0D, 5'd2, 5'd9, 16'h8000), 32'd1, 32'hFFFF_FFFF);
    n_cmp++; if ({alu_op0, alu_b0} !== {4'b0001, 32'h0000_8000}) begin n_bad++; $display("FAIL ori_issue got %h want %h", {alu_op0, alu_b0}, {4'b0001, 32'h0000_8000}); end
    wait_valid0(k);
    n_cmp++; if ({out_valid0, out_result0, out_rd0} !== {1'b1, 32'h0000_8001, 5'd9}) begin n_bad++; $display("FAIL ori_result got %h want %h", {out_valid0, out_result0, out_rd0}, {1'b1, 32'h0000_8001, 5'd9}); end
    cyc();
    n_cmp++; if (op_count0 !== 16'd3) begin n_bad++; $display("FAIL imm_cnt got %0d want 3", op_count0); end
  endtask

  task automatic test_backpressure();
    int k;
    out_ready = 1'b0;
    accept0(rtype(5'd2, 5'd3, 5'd4, 6'h22), 32'd10, 32'd3);
    n_cmp++; if (alu_op0 !== 4'b0110) begin n_bad++; $display("FAIL sub_op got %b want 0110", alu_op0); end
    wait_valid0(k);
    n_cmp++; if ({out_valid0, out_result0, out_rd0} !== {1'b1, 32'd7, 5'd4}) begin n_bad++; $display("FAIL sub_result got %h want %h", {out_valid0, out_result0, out_rd0}, {1'b1, 32'd7, 5'd4}); end
    instr = rtype(5'd1, 5'd1, 5'd8, 6'h24); rs_data = 32'hFF; rt_data = 32'h0F; in_valid0 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_cmp++; if ({out_valid0, in_ready0, out_result0, out_rd0, alu_op0} !== {1'b1, 1'b0, 32'd7, 5'd4, 4'b0110}) begin n_bad++; $display("FAIL hold_stable[%0d] got %h want %h", c, {out_valid0, in_ready0, out_result0, out_rd0, alu_op0}, {1'b1, 1'b0, 32'd7, 5'd4, 4'b0110}); end
    end
    in_valid0 = 1'b0; out_ready = 1'b1;
    cyc();
    n_cmp++; if ({out_valid0, in_ready0, op_count0} !== {1'b0, 1'b1, 16'd4}) begin n_bad++; $display("FAIL release got %h want %h", {out_valid0, in_ready0, op_count0}, {1'b0, 1'b1, 16'd4}); end
    cyc();
    n_cmp++; if ({out_valid0, in_ready0, op_count0} !== {1'b0, 1'b1, 16'd4}) begin n_bad++; $display("FAIL ignored_op got %h want %h", {out_valid0, in_ready0, op_count0}, {1'b0, 1'b1, 16'd4}); end
  endtask

  task automatic test_illegal();
    accept0({6'h3F, 26'h0}, 32'd1, 32'd2);
    n_cmp++; if ({out_valid0, out_illegal0, out_result0} !== {1'b1, 1'b1, 32'd0}) begin n_bad++; $display("FAIL illegal_out got %h want %h", {out_valid0, out_illegal0, out_result0}, {1'b1, 1'b1, 32'd0}); end
    n_cmp++; if ({alu_op0, alu_a0, alu_b0} !== {4'b0110, 32'd10, 32'd3}) begin n_bad++; $display("FAIL illegal_alu_kept got %h want %h", {alu_op0, alu_a0, alu_b0}, {4'b0110, 32'd10, 32'd3}); end
    cyc();
    n_cmp++; if ({out_valid0, op_count0} !== {1'b0, 16'd5}) begin n_bad++; $display("FAIL illegal_cnt got %h want %h", {out_valid0, op_count0}, {1'b0, 16'd5}); end
  endtask

  task automatic test_slt_nor();
    int k;
    alu_force = 1'b1;
    accept0(rtype(5'd1, 5'd2, 5'd5, 6'h2A), 32'hFFFF_FFFF, 32'd1);
    n_cmp++; if (alu_op0 !== 4'b0111) begin n_bad++; $display("FAIL slt_op got %b want 0111", alu_op0); end
    wait_valid0(k);
    n_cmp++; if ({out_illegal0, out_result0, out_rd0} !== {1'b0, SLT_EXP, 5'd5}) begin n_bad++; $display("FAIL slt_result got %h want %h", {out_illegal0, out_result0, out_rd0}, {1'b0, SLT_EXP, 5'd5}); end
    cyc();
    accept0(rtype(5'd1, 5'd2, 5'd6, 6'h27), 32'h0F0F_0000, 32'h0000_00F0);
    wait_valid0(k);
    n_cmp++; if ({alu_op0, out_result0} !== {4'b1100, NOR_EXP}) begin n_bad++; $display("FAIL nor_result got %h want %h", {alu_op0, out_result0}, {4'b1100, NOR_EXP}); end
    cyc();
    alu_force = 1'b0;
    n_cmp++; if (op_count0 !== 16'd7) begin n_bad++; $display("FAIL slt_nor_cnt got %0d want 7", op_count0); end
  endtask

  task automatic test_lat3();
    int k;
    out_ready = 1'b1;
    accept3(rtype(5'd1, 5'd2, 5'd3, 6'h21), 32'd7, 32'd8);
    n_cmp++; if ({in_ready3, alu_op3} !== {1'b0, 4'b0010}) begin n_bad++; $display("FAIL lat3_issue got %h want %h", {in_ready3, alu_op3}, {1'b0, 4'b0010}); end
    wait_valid3(k);
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL lat3_latency got %0d want 5", k); end
    n_cmp++; if ({out_result3, out_rd3} !== {32'd15, 5'd3}) begin n_bad++; $display("FAIL lat3_result got %h want %h", {out_result3, out_rd3}, {32'd15, 5'd3}); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      accept3(rtype(5'd1, 5'd2, 5'd3, 6'h25), 32'd1, 32'd2);
      wait_valid3(k);
      cyc();
    end
    n_cmp++; if (op_count3 !== 2'd3) begin n_bad++; $display("FAIL lat3_cnt got %0d want 3", op_count3); end
    accept3(rtype(5'd1, 5'd2, 5'd3, 6'h25), 32'd1, 32'd2);
    wait_valid3(k);
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL lat3_timeout got %0d want 5", k); end
    cyc();
    n_cmp++; if (op_count3 !== 2'd0) begin n_bad++; $display("FAIL lat3_wrap got %0d want 0", op_count3); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    accept3(itype(6'h0C, 5'd1, 5'd4, 16'h00F0), 32'h1234, 32'h0);
    n_cmp++; if ({alu_op3, alu_b3} !== {4'b0000, 32'h0000_00F0}) begin n_bad++; $display("FAIL andi_issue got %h want %h", {alu_op3, alu_b3}, {4'b0000, 32'h0000_00F0}); end
    cyc();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready3, out_valid3, alu_a3, alu_b3, out_rd3} !== {1'b1, 1'b0, 32'h0, 32'h0, 5'd0}) begin n_bad++; $display("FAIL mid_reset got %h want %h", {in_ready3, out_valid3, alu_a3, alu_b3, out_rd3}, {1'b1, 1'b0, 32'h0, 32'h0, 5'd0}); end
    n_cmp++; if ({op_count0, out_result0} !== 48'h0) begin n_bad++; $display("FAIL mid_reset_dut0 got %h want 0", {op_count0, out_result0}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin cyc(); if (out_valid3) seen = 1'b1; end
    n_cmp++; if ({seen, op_count3} !== 3'b000) begin n_bad++; $display("FAIL discarded got %b want 000", {seen, op_count3}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_backpressure();
    test_illegal();
    test_slt_nor();
    test_lat3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
